// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first serial-to-parallel receiver (start bit + W data bits [+ even parity]) feeding a 2-entry output FIFO.
// Latency: word is visible on o/ov one cycle after the edge that samples its final bit (when the FIFO is empty).
// Backpressure: valid/ready pop; a word completed while the FIFO is full and not popping is dropped and sets sticky ovr.
// Optional feature: define SIPO_RX_PARITY_EN to add the PAR state and the even-parity check on pe.
module sipo_rx #(
  parameter int W = 4
) (
  input  logic         c,
  input  logic         r,
  input  logic         en,
  input  logic         si,
  output logic [W-1:0] o,
  output logic         ov,
  input  logic         ordy,
  output logic         pe,
  output logic         ovr,
  output logic         busy
);

  localparam int KW = $clog2(W);
`ifdef SIPO_RX_PARITY_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DATA
`ifdef SIPO_RX_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  sr;

  logic          push_vld;
  logic [W-1:0]  push_word;
`ifdef SIPO_RX_PARITY_EN
  logic          push_pe;
`endif

  logic [EW-1:0] mem [2];
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;
  logic          pop;
  logic          full;
  logic          wr;
  logic [EW-1:0] head;

  // Decode the edge that samples a frame's final bit into a push request.
  always_comb begin
    push_vld  = 1'b0;
    push_word = sr;
`ifdef SIPO_RX_PARITY_EN
    push_pe   = 1'b0;
`endif
    if (en) begin
      case (state)
`ifdef SIPO_RX_PARITY_EN
        PAR: begin
          push_vld = 1'b1;
          push_pe  = ^{sr, si};
        end
`else
        DATA: begin
          if (k == KW'(W - 1)) begin
            push_vld  = 1'b1;
            push_word = {sr[W-2:0], si};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Frame FSM: hunt for the start bit, shift in data MSB first, optionally take the parity bit.
  always_ff @(posedge c) begin
    if (r) begin
      state <= IDLE;
      k     <= '0;
      sr    <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (si) begin
            state <= DATA;
            k     <= '0;
          end
        end
        DATA: begin
          sr <= {sr[W-2:0], si};
          k  <= k + KW'(1);
          if (k == KW'(W - 1)) begin
`ifdef SIPO_RX_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  assign pop  = ov & ordy;
  assign full = (cnt == 2'd2);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign wr   = push_vld & (~full | pop);

  // Two-entry FIFO with sticky overrun on a dropped word.
  always_ff @(posedge c) begin
    if (r) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
      ovr    <= 1'b0;
    end else begin
      if (wr) begin
`ifdef SIPO_RX_PARITY_EN
        mem[wp] <= {push_pe, push_word};
`else
        mem[wp] <= push_word;
`endif
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      case ({wr, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (push_vld && full && !pop) begin
        ovr <= 1'b1;
      end
    end
  end

  assign head = mem[rp];
  assign ov   = (cnt != 2'd0);
  assign o    = head[W-1:0];
`ifdef SIPO_RX_PARITY_EN
  assign pe   = head[W];
`else
  assign pe   = 1'b0;
`endif

endmodule
